// File: rtl/gat_pkg.sv
// gat_pkg: shared FSM states and constants for the GAT feature readback engine
package gat_pkg;
  typedef enum logic [1:0] {RB_IDLE, RB_WAIT_RDY, RB_STREAM, RB_FLUSH} rb_state_e;
  localparam int RD_LATENCY_DEF = 2;
  localparam int STREAM_W = 32;
endpackage

// File: rtl/gat_rb_fifo.sv
// gat_rb_fifo: small synchronous FIFO with occupancy count, absorbs BRAM read latency
// ports: clk, rst_n (async active-low), push/din write side, pop/dout read side (dout = head),
//        count = current occupancy; push at full is legal only together with pop
module gat_rb_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 32,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? (wr_q == LAST_P ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? (rd_q == LAST_P ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/gat_feat_readback.sv
// gat_feat_readback: drains the GAT new-feature BRAM into a 32-bit valid/ready stream
// ports: clk, rst_n (async active-low), start, gat_ready, feat_bram_addrb (byte address),
//        feat_bram_dout (data RD_LATENCY cycles after address), m_tdata/m_tvalid/m_tready/m_tlast,
//        busy (start accepted until done), done (one-cycle pulse after the last beat)
// GAT_FEAT_RB_ROW_LAST_EN: when defined, m_tlast closes every node row instead of only the drain
module gat_feat_readback
  import gat_pkg::*;
#(
  parameter int NUM_SUBGRAPHS = 2708,
  parameter int NUM_FEATURE_OUT = 16,
  parameter int NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int FEAT_WIDTH = 31,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [FEAT_WIDTH-1:0]         feat_bram_dout,
  output logic [STREAM_W-1:0]           m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          done
);
  localparam int FIFO_D = RD_LATENCY + 1;
  localparam int FCW = $clog2(FIFO_D + 1);
  localparam int CW = NEW_FEATURE_ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(NEW_FEATURE_DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(NEW_FEATURE_DEPTH - 1);
  localparam logic [NEW_FEATURE_ADDR_W-1:0] ADDR_LAST = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  rb_state_e state_q, state_d;
  logic [CW-1:0] issued_q, issued_d, beat_q, beat_d;
  logic [NEW_FEATURE_ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic done_q, done_d, busy_q, busy_d;
  logic pop, issue, accept, last_beat;
  logic [FCW-1:0] fifo_cnt;
  always_comb begin
    pop = m_tvalid && m_tready;
    accept = state_q == RB_IDLE && start;
    last_beat = beat_q == LAST_C;
    issue = state_q == RB_STREAM && issued_q < DEPTH_C &&
            ($countones(vld_q) + int'(fifo_cnt) - int'(pop) < FIFO_D);
    case (state_q)
      RB_IDLE:     state_d = start ? RB_WAIT_RDY : RB_IDLE;
      RB_WAIT_RDY: state_d = gat_ready ? RB_STREAM : RB_WAIT_RDY;
      RB_STREAM:   state_d = issue && issued_q == LAST_C ? RB_FLUSH : RB_STREAM;
      default:     state_d = pop && last_beat ? RB_IDLE : RB_FLUSH;
    endcase
    issued_d = accept ? '0 : issued_q + CW'(issue);
    addr_d = accept ? '0 : (issue && addr_q != ADDR_LAST) ? addr_q + 1'b1 : addr_q;
    beat_d = accept ? '0 : beat_q + CW'(pop);
    vld_d = RD_LATENCY'({vld_q, issue});
    done_d = state_q == RB_FLUSH && pop && last_beat;
    busy_d = state_d != RB_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RB_IDLE;
      issued_q <= '0;
      beat_q <= '0;
      addr_q <= '0;
      vld_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issued_q <= issued_d;
      beat_q <= beat_d;
      addr_q <= addr_d;
      vld_q <= vld_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  gat_rb_fifo #(.DEPTH(FIFO_D), .WIDTH(STREAM_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_q[RD_LATENCY-1]),
    .din   (STREAM_W'(feat_bram_dout)),
    .pop   (pop),
    .dout  (m_tdata),
    .count (fifo_cnt)
  );
  assign feat_bram_addrb = {addr_q, 2'b00};
  assign m_tvalid = fifo_cnt != '0;
`ifdef GAT_FEAT_RB_ROW_LAST_EN
  assign m_tlast = m_tvalid && (beat_q % CW'(NUM_FEATURE_OUT) == CW'(NUM_FEATURE_OUT - 1));
`else
  assign m_tlast = m_tvalid && last_beat;
`endif
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_gat_feat_readback.sv
// tb_gat_feat_readback: directed scoreboard bench for the feature readback engine
module tb_gat_feat_readback;
  logic clk = 0, rst_n = 0, start = 0, gat_ready = 0, m_tready = 0;
  logic [5:0] addrb;
  logic [30:0] dout, p1;
  logic [31:0] m_tdata;
  logic m_tvalid, m_tlast, busy, done;
  int errors = 0, checks = 0, cyc = 0, hs_cnt = 0, first_v = -1, last_hs = -1;
  logic [32:0] exp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    p1 <= 31'h100 + {27'b0, addrb[5:2]};
    dout <= p1;
  end
  gat_feat_readback #(.NUM_SUBGRAPHS(3), .NUM_FEATURE_OUT(4), .RD_LATENCY(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .gat_ready       (gat_ready),
    .feat_bram_addrb (addrb),
    .feat_bram_dout  (dout),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast),
    .busy            (busy),
    .done            (done)
  );
  function automatic logic exp_last(int i);
`ifdef GAT_FEAT_RB_ROW_LAST_EN
    return i % 4 == 3;
`else
    return i == 11;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (m_tvalid && m_tready) begin
        hs_cnt++;
        last_hs = cyc;
        chk("beat_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("beat_data", m_tdata, e[31:0]);
          chk("beat_last", {31'b0, m_tlast}, {31'b0, e[32]});
        end
      end
    end
  task automatic push_all();
    for (int i = 0; i < 12; i++) exp_q.push_back({exp_last(i), 32'h100 + 32'(i)});
    hs_cnt = 0;
    first_v = -1;
  endtask
  task automatic pulse_start(output int s);
    @(posedge clk);
    #1 start = 1;
    s = cyc;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done(input int budget, input bit rnd, output int dc, output logic b);
    dc = -1;
    b = 1;
    for (int i = 0; i < budget && dc < 0; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        b = busy;
      end else begin
        @(posedge clk);
        #1;
        if (rnd) m_tready = 1'($urandom_range(0, 1));
      end
    end
    chk("done_seen", {31'b0, dc >= 0}, 32'd1);
  endtask
  task automatic check_drain(input string tag, input int s, input int dc, input logic b, input bit timed);
    chk({tag, "_beats"}, 32'(hs_cnt), 32'd12);
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done_after_last"}, 32'(dc), 32'(last_hs + 1));
    chk({tag, "_busy_at_done"}, {31'b0, b}, 32'd0);
    if (timed) begin
      chk({tag, "_first_valid"}, 32'(first_v - s), 32'd5);
      chk({tag, "_done_cycle"}, 32'(dc - s), 32'd17);
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int s, dc, bad;
    logic b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addrb", {26'b0, addrb}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("rst_tlast", {31'b0, m_tlast}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    gat_ready = 1;
    m_tready = 1;
    push_all();
    pulse_start(s);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    wait_done(100, 0, dc, b);
    check_drain("t1", s, dc, b, 1);
    gat_ready = 0;
    push_all();
    pulse_start(s);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (addrb != 0 || m_tvalid) bad++;
    end
    chk("t2_no_reads_before_ready", 32'(bad), 32'd0);
    chk("t2_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1 gat_ready = 1;
    wait_done(100, 0, dc, b);
    check_drain("t2", s, dc, b, 0);
    m_tready = 0;
    push_all();
    pulse_start(s);
    wait_done(300, 1, dc, b);
    check_drain("t3", s, dc, b, 0);
    m_tready = 0;
    push_all();
    pulse_start(s);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_tvalid && m_tdata != 32'h100) bad++;
    end
    chk("t4_data_held", 32'(bad), 32'd0);
    chk("t4_tvalid", {31'b0, m_tvalid}, 32'd1);
    chk("t4_tdata", m_tdata, 32'h100);
    chk("t4_reads_bounded", {31'b0, addrb <= 6'h0C}, 32'd1);
    chk("t4_no_beats", 32'(hs_cnt), 32'd0);
    @(posedge clk);
    #1 m_tready = 1;
    wait_done(100, 0, dc, b);
    check_drain("t4", s, dc, b, 0);
    push_all();
    pulse_start(s);
    for (int i = 0; i < 100 && hs_cnt < 5; i++) @(negedge clk);
    chk("t5_reached_beat5", {31'b0, hs_cnt >= 5}, 32'd1);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("t5_rst_addrb", {26'b0, addrb}, 32'd0);
    chk("t5_rst_tdata", m_tdata, 32'd0);
    chk("t5_rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("t5_rst_tlast", {31'b0, m_tlast}, 32'd0);
    chk("t5_rst_busy", {31'b0, busy}, 32'd0);
    chk("t5_rst_done", {31'b0, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("t5_addr_after_rst", {26'b0, addrb}, 32'd0);
    push_all();
    pulse_start(s);
    wait_done(100, 0, dc, b);
    check_drain("t5", s, dc, b, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
